// File: rtl/gp_chain_pipe.sv
// gp_chain_pipe
//   Pipelined generate/propagate carry chain.  Each bit computes
//   c[i] = g[i] | (p[i] & c[i-1]) with c[-1] = in_cin.  The chain is cut
//   into SEG-bit segments, with one register stage per segment.  STAGES is
//   ceil(N/SEG), and that is also the latency in cycles.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   input vector present
//   in_ready   out  block accepts the input vector this cycle
//   in_g       in   [N] generate bits, bit 0 is first in the chain
//   in_p       in   [N] propagate bits
//   in_cin     in   chain carry-in
//   out_valid  out  result present
//   out_ready  in   downstream accepts the result
//   out_c      out  [N] carry after each bit
//   out_cout   out  final carry c[N-1]
//   out_pall   out  AND of all propagate bits
//
// Handshake: a vector moves across a boundary on any rising edge where the
// sender's valid and the receiver's ready are both 1.  A sender holds its
// data while valid=1 and ready=0.  Ready does not depend on valid in the
// same cycle, so no combinational path runs from in_valid to any output.
module gp_chain_pipe #(
   parameter int N   = 5,
   parameter int SEG = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_g,
   input  logic [N-1:0] in_p,
   input  logic         in_cin,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_c,
   output logic         out_cout,
   output logic         out_pall
);

   localparam int STAGES = (N + SEG - 1) / SEG;

   // The full g/p vectors travel with the data.  Each stage reads only its
   // own segment, so synthesis trims the bits that are already consumed.
   typedef struct packed {
      logic [N-1:0] g;
      logic [N-1:0] p;
      logic [N-1:0] c;
      logic         carry;
      logic         pall;
   } stage_t;

   // Evaluate segment k on top of the running carry and running pall.
   function automatic stage_t eval_seg(input stage_t s, input int k);
      stage_t r;
      logic   cy;
      logic   pa;
      r  = s;
      cy = s.carry;
      pa = s.pall;
      for (int i = 0; i < N; i++) begin
         if (i >= k * SEG && i < (k + 1) * SEG) begin
            cy     = s.g[i] | (s.p[i] & cy);
            r.c[i] = cy;
            pa     = pa & s.p[i];
         end
      end
      r.carry = cy;
      r.pall  = pa;
      return r;
   endfunction

   stage_t            src   [STAGES];
   stage_t            st_d  [STAGES];
   stage_t            st_q  [STAGES];
   logic [STAGES-1:0] src_v;
   logic [STAGES-1:0] vld_d;
   logic [STAGES-1:0] vld_q;
   logic [STAGES-1:0] rdy;

   // Upstream view of each stage: stage 0 sees the input port, which starts
   // with a carry of in_cin and pall=1.
   always_comb begin
      src[0]   = '{g: in_g, p: in_p, c: '0, carry: in_cin, pall: 1'b1};
      src_v[0] = in_valid;
      for (int k = 1; k < STAGES; k++) begin
         src[k]   = st_q[k-1];
         src_v[k] = vld_q[k-1];
      end
   end

   // rdy_k = !valid_k | rdy_{k+1}, with rdy_STAGES = out_ready.  The
   // recurrence is unrolled: a stage can load if downstream is ready or if
   // any stage at or after it holds a bubble.
   always_comb begin
      for (int k = 0; k < STAGES; k++) begin
         st_d[k]  = eval_seg(src[k], k);
         vld_d[k] = src_v[k];
         rdy[k]   = out_ready;
         for (int j = k; j < STAGES; j++) begin
            if (!vld_q[j]) rdy[k] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
         for (int k = 0; k < STAGES; k++) st_q[k] <= '0;
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (rdy[k]) begin
               vld_q[k] <= vld_d[k];
               st_q[k]  <= st_d[k];
            end
         end
      end
   end

   assign in_ready  = rdy[0];
   assign out_valid = vld_q[STAGES-1];
   assign out_c     = st_q[STAGES-1].c;
   assign out_cout  = st_q[STAGES-1].carry;
   assign out_pall  = st_q[STAGES-1].pall;

endmodule

// File: tb/tb_gp_chain_pipe.sv
// Bench for gp_chain_pipe.  It runs three instances side by side on shared
// stimulus: a = (N5,SEG2) with 3 stages, b = (N1,SEG1) with 1 stage, and
// c = (N5,SEG8) with 1 stage.  Each instance has its own expected queue,
// filled from a closed-form carry model.
module tb_gp_chain_pipe;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid;
  logic [4:0] in_g;
  logic [4:0] in_p;
  logic in_cin;
  logic out_ready;

  logic a_in_ready, a_out_valid, a_out_cout, a_out_pall;
  logic [4:0] a_out_c;
  logic b_in_ready, b_out_valid, b_out_cout, b_out_pall;
  logic [0:0] b_out_c;
  logic c_in_ready, c_out_valid, c_out_cout, c_out_pall;
  logic [4:0] c_out_c;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int a_acc = 0, b_acc = 0, c_acc = 0;
  int a_emits[$];
  logic [6:0] exp_a[$];
  logic [6:0] exp_b[$];
  logic [6:0] exp_c[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  gp_chain_pipe #(.N(5), .SEG(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_g(in_g), .in_p(in_p), .in_cin(in_cin),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_c(a_out_c),
    .out_cout(a_out_cout), .out_pall(a_out_pall));

  gp_chain_pipe #(.N(1), .SEG(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_g(in_g[0:0]), .in_p(in_p[0:0]), .in_cin(in_cin),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_c(b_out_c),
    .out_cout(b_out_cout), .out_pall(b_out_pall));

  gp_chain_pipe #(.N(5), .SEG(8)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(c_in_ready),
    .in_g(in_g), .in_p(in_p), .in_cin(in_cin),
    .out_valid(c_out_valid), .out_ready(out_ready), .out_c(c_out_c),
    .out_cout(c_out_cout), .out_pall(c_out_pall));

  // ---------------- reference model ----------------
  // Closed form: c[i] is 1 when some bit j<=i generates and every bit
  // after j up to i propagates, or when cin propagates through bits 0..i.
  // The result is packed as {pall, cout, c[4:0]}.
  function automatic logic [6:0] gold(input logic [4:0] g, input logic [4:0] p,
                                      input logic cin, input int n);
    logic [4:0] c;
    logic pall;
    logic all_p;
    c = '0;
    for (int i = 0; i < n; i++) begin
      all_p = 1'b1;
      for (int k = 0; k <= i; k++) all_p = all_p & p[k];
      if (cin && all_p) c[i] = 1'b1;
      for (int j = 0; j <= i; j++) begin
        all_p = 1'b1;
        for (int k = j + 1; k <= i; k++) all_p = all_p & p[k];
        if (g[j] && all_p) c[i] = 1'b1;
      end
    end
    pall = 1'b1;
    for (int k = 0; k < n; k++) pall = pall & p[k];
    return {pall, c[n-1], c};
  endfunction

  function automatic logic [6:0] act_a();
    return {a_out_pall, a_out_cout, a_out_c};
  endfunction
  function automatic logic [6:0] act_b();
    return {b_out_pall, b_out_cout, 4'b0000, b_out_c};
  endfunction
  function automatic logic [6:0] act_c();
    return {c_out_pall, c_out_cout, c_out_c};
  endfunction

  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- scoreboard ----------------
  // Runs once per cycle on the falling edge.  It checks each valid output
  // against the head of its queue, pops on an output transfer, and pushes
  // on an input transfer.  A stalled output is compared again each cycle,
  // which also confirms that it stays stable.
  task automatic scoreboard();
    if (!rst_n) begin
      exp_a.delete(); exp_b.delete(); exp_c.delete();
      return;
    end
    if (a_out_valid) begin
      if (exp_a.size() == 0) chk("a_spurious", 7'd1, 7'd0);
      else chk("a_data", act_a(), exp_a[0]);
      if (out_ready) begin
        if (exp_a.size() > 0) void'(exp_a.pop_front());
        a_emits.push_back(cyc);
      end
    end
    if (b_out_valid) begin
      if (exp_b.size() == 0) chk("b_spurious", 7'd1, 7'd0);
      else chk("b_data", act_b(), exp_b[0]);
      if (out_ready && exp_b.size() > 0) void'(exp_b.pop_front());
    end
    if (c_out_valid) begin
      if (exp_c.size() == 0) chk("c_spurious", 7'd1, 7'd0);
      else chk("c_data", act_c(), exp_c[0]);
      if (out_ready && exp_c.size() > 0) void'(exp_c.pop_front());
    end
    if (in_valid && a_in_ready) begin exp_a.push_back(gold(in_g, in_p, in_cin, 5)); a_acc++; end
    if (in_valid && b_in_ready) begin exp_b.push_back(gold(in_g, in_p, in_cin, 1)); b_acc++; end
    if (in_valid && c_in_ready) begin exp_c.push_back(gold(in_g, in_p, in_cin, 5)); c_acc++; end
  endtask

  // One clock cycle: score on the falling edge, return 1ns after the
  // rising edge so the caller can drive the next inputs.
  task automatic cycle();
    @(negedge clk);
    scoreboard();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // ---------------- driver tasks ----------------
  // Present one vector and hold it until instance a accepts it.
  task automatic drive(input logic [4:0] g, input logic [4:0] p, input logic cin);
    logic rdy;
    int n;
    in_valid = 1'b1; in_g = g; in_p = p; in_cin = cin;
    n = 0;
    rdy = a_in_ready;
    cycle();
    while (!rdy && n < 50) begin
      rdy = a_in_ready;
      cycle();
      n++;
    end
    if (!rdy) chk("drive_timeout", 7'd1, 7'd0);
    in_valid = 1'b0;
  endtask

  // Wait a bounded time for instance a to emit, then check the result
  // against a literal value.
  task automatic expect_a(input string name, input logic [6:0] exp);
    int n;
    n = 0;
    while (!a_out_valid && n < 20) begin cycle(); n++; end
    if (!a_out_valid) chk({name, "_timeout"}, 7'd0, 7'd1);
    else chk(name, act_a(), exp);
    cycle();
  endtask

  // ---------------- tests ----------------
  initial begin
    int acc0, b0, c0, e0;
    logic [6:0] snap;
    rst_n = 1'b0; in_valid = 1'b0; in_g = '0; in_p = '0; in_cin = 1'b0; out_ready = 1'b0;
    #1;
    chk("reset_a", {a_out_valid, a_out_pall, a_out_cout, a_out_c}, 7'd0);
    chk("reset_c", {c_out_valid, c_out_pall, c_out_cout, c_out_c}, 7'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    chk("ready_after_reset", {4'b0, a_in_ready, b_in_ready, c_in_ready}, 7'b0000111);

    // Test 1: full propagation; exact latency 3 on a and 1 on b and c.
    out_ready = 1'b1;
    drive(5'b00000, 5'b11111, 1'b1);
    chk("lat_a_t0", {6'b0, a_out_valid}, 7'd0);
    chk("lat1_c", {c_out_valid, act_c()}, 8'b1_1111111);
    chk("lat1_b", {b_out_valid, act_b()}, 8'b1_1100001);
    cycle();
    chk("lat_a_t1", {6'b0, a_out_valid}, 7'd0);
    cycle();
    chk("lat_a_t2", {a_out_valid, act_a()}, 8'b1_1111111);
    cycle();

    // Test 2: hand-computed vectors.
    drive(5'b00100, 5'b11000, 1'b0);
    drive(5'b00001, 5'b00000, 1'b1);
    expect_a("vec_g2", 7'b0111100);
    expect_a("vec_g0", 7'b0000001);
    repeat (3) cycle();

    // Test 3: 8 random vectors back to back, emitted on consecutive cycles.
    acc0 = a_acc; e0 = a_emits.size();
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_g = 5'($urandom_range(0, 31)); in_p = 5'($urandom_range(0, 31));
      in_cin = 1'($urandom_range(0, 1));
      cycle();
    end
    in_valid = 1'b0;
    repeat (6) cycle();
    chk("stream_accepts", 7'(a_acc - acc0), 7'd8);
    chk("stream_emits", 7'(a_emits.size() - e0), 7'd8);
    if (a_emits.size() >= e0 + 8)
      chk("stream_no_gaps", 7'(a_emits[e0+7] - a_emits[e0]), 7'd7);

    // Test 4: backpressure with in_valid held high.
    out_ready = 1'b0;
    acc0 = a_acc; b0 = b_acc; c0 = c_acc;
    in_valid = 1'b1; in_g = 5'b10110; in_p = 5'b01101; in_cin = 1'b1;
    repeat (4) cycle();
    snap = act_a();
    repeat (4) cycle();
    chk("full_accepts_a", 7'(a_acc - acc0), 7'd3);
    chk("full_accepts_b", 7'(b_acc - b0), 7'd1);
    chk("full_accepts_c", 7'(c_acc - c0), 7'd1);
    chk("full_ready", {4'b0, a_in_ready, b_in_ready, c_in_ready}, 7'd0);
    chk("full_stable", act_a(), snap);
    in_valid = 1'b0; out_ready = 1'b1;
    e0 = a_emits.size();
    repeat (5) cycle();
    chk("release_emits", 7'(a_emits.size() - e0), 7'd3);
    if (a_emits.size() >= e0 + 3)
      chk("release_no_gaps", 7'(a_emits[e0+2] - a_emits[e0]), 7'd2);

    // Test 5: reset with 2 vectors in flight.
    drive(5'b00011, 5'b11100, 1'b0);
    drive(5'b11111, 5'b00000, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_drop_a", {a_out_valid, a_out_pall, a_out_cout, a_out_c}, 7'd0);
    chk("rst_drop_bc", {5'b0, b_out_valid, c_out_valid}, 7'd0);
    cycle(); cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("no_stale", {4'b0, a_out_valid, b_out_valid, c_out_valid}, 7'd0);
    end

    // Random stress: valid and out_ready both toggle.
    for (int i = 0; i < 400; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_g = 5'($urandom_range(0, 31)); in_p = 5'($urandom_range(0, 31));
      in_cin = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (8) cycle();
    chk("drain_a", 7'(exp_a.size()), 7'd0);
    chk("drain_b", 7'(exp_b.size()), 7'd0);
    chk("drain_c", 7'(exp_c.size()), 7'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
